apb_slave_mem_responder: RTL

- APB4 completer (slave) RTL block: the responding end of the APB bus that our APB master agent drives.
- Decodes psel/penable/paddr and inserts a programmable number of wait states via pready.
- Serves reads and byte-strobed writes from a small local word memory.
- Reports pslverr for out-of-range, misaligned or (optionally) protection-violating accesses.
- Used as the bus-side responder in front of SPI-master register space and as a DUT-side stand-in for the APB slave agent.

---
 rtl/apb_slave_global_pkg.sv | 23 ++
 rtl/apb_slave_mem.sv | 36 +++
 rtl/apb_slave_mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_slave_global_pkg.sv
// rtl/apb_slave_global_pkg.sv - shared APB slave types, FSM states and default widths
package apb_slave_global_pkg;

    localparam int APB_ADDRESS_WIDTH = 32;
    localparam int APB_DATA_WIDTH    = 32;

    typedef enum logic {
        NO_ERROR = 1'b0,
        ERROR    = 1'b1
    } slave_error_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - byte-strobed synchronous-write, combinational-read word array
module apb_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    localparam int IDX_W     = $clog2(MEM_DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// rtl/apb_slave_mem_responder.sv - APB4 completer with wait states and local memory; option APB_SLAVE_PROT_CHECK_EN
module apb_slave_mem_responder
    import apb_slave_global_pkg::*;
#(
    parameter int ADDRESS_WIDTH                 = APB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH                    = APB_DATA_WIDTH,
    parameter int MEM_DEPTH                     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    input  logic [3:0]               cfg_wait_states,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(MEM_DEPTH * STRB_W);
    localparam logic [ADDRESS_WIDTH-1:0] BYTE_MASK = ADDRESS_WIDTH'(STRB_W - 1);

    apb_slave_state_e state, state_next;

    logic [3:0]               wait_cnt;
    logic [IDX_W-1:0]         idx_q, cur_idx, rd_idx;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0]    wdata_q, mem_rdata;
    logic [STRB_W-1:0]        strb_q;
    tx_type_e                 dir_q, cur_dir, sel_dir;
    slave_error_e             err_q, cur_err, sel_err;
    logic                     bad, setup, enter_done, mem_we;
    logic                     unused_prot;

    // Offset wraps to a huge value below BASE_ADDR, so a single compare covers both bounds
    assign offset  = paddr - BASE_ADDR;
    assign cur_idx = offset[BYTE_SHIFT +: IDX_W];
    assign cur_dir = pwrite ? WRITE : READ;

    always_comb begin
        bad = (offset >= MEM_BYTES) || ((offset & BYTE_MASK) != '0);
`ifdef APB_SLAVE_PROT_CHECK_EN
        if (pprot[1] && cur_idx[IDX_W-1]) begin
            bad = 1'b1;
        end
`endif
        cur_err = bad ? ERROR : NO_ERROR;
    end

`ifdef APB_SLAVE_PROT_CHECK_EN
    assign unused_prot = pprot[0] ^ pprot[2];
`else
    assign unused_prot = ^pprot;
`endif

    assign setup = (state == IDLE) && psel && !penable;

    // Zero-wait transfers go to DONE on the SETUP edge, before the latches hold the new access
    assign rd_idx  = setup ? cur_idx : idx_q;
    assign sel_err = setup ? cur_err : err_q;
    assign sel_dir = setup ? cur_dir : dir_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_next = (cfg_wait_states == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable && wait_cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign enter_done = (state_next == DONE) && (state != DONE);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt <= '0;
            idx_q    <= '0;
            dir_q    <= READ;
            err_q    <= NO_ERROR;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata   <= '0;
        end else begin
            if (setup) begin
                wait_cnt <= cfg_wait_states;
                idx_q    <= cur_idx;
                dir_q    <= cur_dir;
                err_q    <= cur_err;
                wdata_q  <= pwdata;
                strb_q   <= pstrb;
            end else if (state == WAIT && psel && penable && wait_cnt != 4'd1) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_done) begin
                if (sel_err == ERROR) begin
                    prdata <= '0;
                end else if (sel_dir == READ) begin
                    prdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_we  = (state == DONE) && (dir_q == WRITE) && (err_q == NO_ERROR);
    assign pready  = (state == DONE);
    assign pslverr = pready && (err_q == ERROR);

    apb_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .pclk     (pclk),
        .preset_n (preset_n),
        .we       (mem_we),
        .waddr    (idx_q),
        .wdata    (wdata_q),
        .wstrb    (strb_q),
        .raddr    (rd_idx),
        .rdata    (mem_rdata)
    );

endmodule
